mem_ctrl: RTL



---
 rtl/mem_ctrl_if.sv | 36 +++
 rtl/mem_ctrl.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/mem_ctrl_if.sv
// Request/response and memory-side bus of the mem_ctrl memory controller.
// slave  : the controller's view (takes requests, drives strobes and results).
// master : the requester and memory side (drives requests and mem_rdata).
interface mem_ctrl_if;
  logic        fetch_req;
  logic [15:0] pc;
  logic        ld_req;
  logic        st_req;
  logic [15:0] daddr;
  logic [15:0] wdata;
  logic        busy;
  logic        inst_valid;
  logic [15:0] inst;
  logic        ld_valid;
  logic [15:0] ld_data;
  logic        st_done;
  logic        req_drop;
  logic        addr_err;
  logic [15:0] mem_addr;
  logic [15:0] mem_data;
  logic        mem_read;
  logic        mem_write;
  logic [15:0] mem_rdata;

  modport slave (
    input  fetch_req, pc, ld_req, st_req, daddr, wdata, mem_rdata,
    output busy, inst_valid, inst, ld_valid, ld_data, st_done, req_drop,
           addr_err, mem_addr, mem_data, mem_read, mem_write
  );

  modport master (
    output fetch_req, pc, ld_req, st_req, daddr, wdata, mem_rdata,
    input  busy, inst_valid, inst, ld_valid, ld_data, st_done, req_drop,
           addr_err, mem_addr, mem_data, mem_read, mem_write
  );
endinterface

// File: rtl/mem_ctrl.sv
// mem_ctrl: single-outstanding memory controller arbitrating stores, loads
// and instruction fetches onto one memory port with a one-cycle registered
// read path. States IDLE -> ISSUE -> (WAIT) -> IDLE; every output registered.
// Optional feature: define MEM_CTRL_ADDR_CHECK_EN to reject accesses whose
// address bits [15:8] are non-zero (addr_err pulse, no memory strobe, the
// completion pulse still fires with data unchanged). Without it addr_err is 0.
module mem_ctrl (
  input  logic       clk,
  input  logic       rst,
  mem_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    K_FETCH = 2'd0,
    K_LOAD  = 2'd1,
    K_STORE = 2'd2
  } kind_t;

  state_t      state_r;
  kind_t       kind_r;

  logic        any_req_s;
  logic        multi_req_s;
  kind_t       win_kind_s;
  logic [15:0] win_addr_s;
  logic        addr_bad_s;

  // Request arbitration: store beats load beats fetch; flag simultaneous requests.
  always_comb begin
    any_req_s   = bus.st_req | bus.ld_req | bus.fetch_req;
    multi_req_s = (bus.st_req & bus.ld_req) | (bus.st_req & bus.fetch_req) |
                  (bus.ld_req & bus.fetch_req);
    if (bus.st_req) begin
      win_kind_s = K_STORE;
    end else if (bus.ld_req) begin
      win_kind_s = K_LOAD;
    end else begin
      win_kind_s = K_FETCH;
    end
    if (bus.st_req || bus.ld_req) begin
      win_addr_s = bus.daddr;
    end else begin
      win_addr_s = bus.pc;
    end
  end

`ifdef MEM_CTRL_ADDR_CHECK_EN
  assign addr_bad_s = |win_addr_s[15:8];
`else
  assign addr_bad_s   = 1'b0;
  assign bus.addr_err = 1'b0;
`endif

  // Controller FSM with all outputs registered alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r        <= IDLE;
      kind_r         <= K_FETCH;
      bus.busy       <= 1'b0;
      bus.inst_valid <= 1'b0;
      bus.inst       <= 16'h0000;
      bus.ld_valid   <= 1'b0;
      bus.ld_data    <= 16'h0000;
      bus.st_done    <= 1'b0;
      bus.req_drop   <= 1'b0;
      bus.mem_addr   <= 16'h0000;
      bus.mem_data   <= 16'h0000;
      bus.mem_read   <= 1'b0;
      bus.mem_write  <= 1'b0;
`ifdef MEM_CTRL_ADDR_CHECK_EN
      bus.addr_err   <= 1'b0;
`endif
    end else begin
      // Pulses and strobes are one cycle wide unless re-asserted below.
      bus.inst_valid <= 1'b0;
      bus.ld_valid   <= 1'b0;
      bus.st_done    <= 1'b0;
      bus.mem_read   <= 1'b0;
      bus.mem_write  <= 1'b0;
`ifdef MEM_CTRL_ADDR_CHECK_EN
      bus.addr_err   <= 1'b0;
`endif
      // Anything arriving outside IDLE is lost; remember that stickily.
      if (any_req_s && (state_r != IDLE)) begin
        bus.req_drop <= 1'b1;
      end
      case (state_r)
        IDLE: begin
          if (any_req_s) begin
            if (multi_req_s) begin
              bus.req_drop <= 1'b1;
            end
            kind_r <= win_kind_s;
            if (addr_bad_s) begin
              // Rejected access: no memory cycle, complete immediately.
`ifdef MEM_CTRL_ADDR_CHECK_EN
              bus.addr_err <= 1'b1;
`endif
              case (win_kind_s)
                K_STORE: bus.st_done    <= 1'b1;
                K_LOAD:  bus.ld_valid   <= 1'b1;
                default: bus.inst_valid <= 1'b1;
              endcase
            end else begin
              state_r      <= ISSUE;
              bus.busy     <= 1'b1;
              bus.mem_addr <= win_addr_s;
              if (win_kind_s == K_STORE) begin
                bus.mem_data  <= bus.wdata;
                bus.mem_write <= 1'b1;
              end else begin
                bus.mem_read  <= 1'b1;
              end
            end
          end
        end
        ISSUE: begin
          if (kind_r == K_STORE) begin
            state_r     <= IDLE;
            bus.busy    <= 1'b0;
            bus.st_done <= 1'b1;
          end else begin
            state_r     <= WAIT;
          end
        end
        WAIT: begin
          // Memory read data is valid now; mem_addr has been held since ISSUE.
          state_r  <= IDLE;
          bus.busy <= 1'b0;
          if (kind_r == K_FETCH) begin
            bus.inst       <= bus.mem_rdata;
            bus.inst_valid <= 1'b1;
          end else begin
            bus.ld_data    <= bus.mem_rdata;
            bus.ld_valid   <= 1'b1;
          end
        end
        default: begin
          state_r  <= IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
